// File: rtl/wm_pkg.sv
// Shared definitions for the washing-machine phase timer.
// Holds the phase encodings, the timer state enum, the wash-mode index type,
// the 3x4 phase duration table (in time units) and the lookup helpers.
// No ports: imported with `import wm_pkg::*;`.
package wm_pkg;

  typedef enum logic [1:0] {
    PhaseSoak  = 2'b00,
    PhaseWash  = 2'b01,
    PhaseRinse = 2'b10,
    PhaseSpin  = 2'b11
  } wm_phase_e;

  typedef enum logic [1:0] {
    WmIdle  = 2'b00,
    WmLoad  = 2'b01,
    WmCount = 2'b10,
    WmDone  = 2'b11
  } wm_state_e;

  typedef enum logic [1:0] {
    Mode1 = 2'd0,
    Mode2 = 2'd1,
    Mode3 = 2'd2
  } wm_mode_e;

  // Indexed [mode][phase]; each row is packed {spin, rinse, wash, soak}.
  typedef logic [2:0][3:0][7:0] wm_dur_table_t;

  localparam wm_dur_table_t WmDurTable = {
    8'd8, 8'd12, 8'd16, 8'd8,  // mode3
    8'd4, 8'd6,  8'd8,  8'd4,  // mode2
    8'd2, 8'd3,  8'd4,  8'd2   // mode1
  };

  // Fixed priority mode1 > mode2 > mode3; nothing selected falls back to mode1.
  function automatic wm_mode_e wm_mode_decode(input logic m1, input logic m2, input logic m3);
    wm_mode_e mode;
    if (m1) begin
      mode = Mode1;
    end else if (m2) begin
      mode = Mode2;
    end else if (m3) begin
      mode = Mode3;
    end else begin
      mode = Mode1;
    end
    return mode;
  endfunction

  // A zero table entry would never expire, so it is promoted to one unit.
  function automatic logic [7:0] wm_duration(input wm_mode_e mode, input logic [1:0] phase);
    logic [7:0] dur;
    dur = WmDurTable[mode][phase];
    return (dur == 8'd0) ? 8'd1 : dur;
  endfunction

endpackage

// File: rtl/wm_phase_timer_if.sv
// Bus between the wash controller (master) and the phase timer (slave).
//   timer_enable      run request
//   phase_sel[1:0]    00 soak, 01 wash, 10 rinse, 11 spin
//   mode1/mode2/mode3 wash-mode selects (mode1 has priority)
//   lid               0 closed, 1 open
//   timer_done        one-cycle pulse at phase expiry
//   remaining[7:0]    units left in the current phase
//   busy              counting (including paused)
//   paused            counting frozen by an open lid
interface wm_phase_timer_if;

  logic       timer_enable;
  logic [1:0] phase_sel;
  logic       mode1;
  logic       mode2;
  logic       mode3;
  logic       lid;
  logic       timer_done;
  logic [7:0] remaining;
  logic       busy;
  logic       paused;

  modport master (
    output timer_enable, phase_sel, mode1, mode2, mode3, lid,
    input  timer_done, remaining, busy, paused
  );

  modport slave (
    input  timer_enable, phase_sel, mode1, mode2, mode3, lid,
    output timer_done, remaining, busy, paused
  );

endinterface

// File: rtl/wm_prescaler.sv
// Unit-tick prescaler: counts clock cycles 0..UNIT_CYCLES-1 and pulses
// tick_o on the cycle that wraps back to 0.
//   clk      system clock, rising edge
//   rst_n    asynchronous active-low reset
//   clear_i  force the count to 0 (wins over hold_i)
//   hold_i   freeze the count
//   tick_o   high in the cycle whose edge wraps the count
module wm_prescaler #(
  parameter int unsigned UNIT_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic hold_i,
  output logic tick_o
);

  localparam logic [15:0] CntMax = 16'(UNIT_CYCLES - 1);

  logic [15:0] cnt_q, cnt_d;
  logic        wrap;

  assign wrap   = (cnt_q == CntMax);
  assign tick_o = !clear_i && !hold_i && wrap;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (!hold_i) begin
      cnt_d = wrap ? '0 : cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/wm_phase_timer.sv
// Washing-machine phase timer. Loads the duration for the selected wash mode
// and phase, counts it down in units of UNIT_CYCLES clocks and pulses
// timer_done once when the phase expires.
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    wm_phase_timer_if.slave (controller inputs, timer status outputs)
// Build option: define WM_LID_PAUSE_EN to freeze counting while the lid is
// open; without it lid is ignored and paused stays 0.
module wm_phase_timer
  import wm_pkg::*;
#(
  parameter int unsigned UNIT_CYCLES = 1000
) (
  input logic              clk,
  input logic              rst_n,
  wm_phase_timer_if.slave  bus
);

  localparam logic [1:0] StIdle  = WmIdle;
  localparam logic [1:0] StLoad  = WmLoad;
  localparam logic [1:0] StCount = WmCount;
  localparam logic [1:0] StDone  = WmDone;

  logic [1:0] state_q, state_d;
  logic [1:0] phase_q, phase_d;
  wm_mode_e   mode_q, mode_d;
  logic [7:0] remaining_q, remaining_d;
  logic       done_q, done_d;

  wm_mode_e   mode_sel;
  logic       phase_change;
  logic       pause_active;
  logic       presc_clear;
  logic       unit_tick;

  assign mode_sel     = wm_mode_decode(bus.mode1, bus.mode2, bus.mode3);
  assign phase_change = (bus.phase_sel != phase_q);

`ifdef WM_LID_PAUSE_EN
  assign pause_active = (state_q == StCount) && bus.lid;
`else
  logic unused_lid;
  assign unused_lid   = bus.lid;
  assign pause_active = 1'b0;
`endif

  // Clear whenever the next state cannot be a continuing COUNT, so the
  // prescaler is already 0 on entry to IDLE or LOAD.
  assign presc_clear = (state_q != StCount) || !bus.timer_enable || phase_change;

  wm_prescaler #(
    .UNIT_CYCLES (UNIT_CYCLES)
  ) u_prescaler (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (presc_clear),
    .hold_i  (pause_active),
    .tick_o  (unit_tick)
  );

  // Phase and mode are captured on every transition into LOAD; the LOAD
  // cycle then fetches the duration from the captured values, so later
  // mode changes have no effect until the next LOAD.
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    mode_d      = mode_q;
    remaining_d = remaining_q;
    done_d      = 1'b0;

    if (!bus.timer_enable) begin
      state_d     = StIdle;
      remaining_d = '0;
    end else begin
      case (state_q)
        StIdle: begin
          state_d = StLoad;
          phase_d = bus.phase_sel;
          mode_d  = mode_sel;
        end
        StLoad: begin
          state_d     = StCount;
          remaining_d = wm_duration(mode_q, phase_q);
        end
        StCount: begin
          if (phase_change) begin
            // Also covers a phase change on the terminal wrap: no pulse.
            state_d = StLoad;
            phase_d = bus.phase_sel;
            mode_d  = mode_sel;
          end else if (unit_tick) begin
            if (remaining_q <= 8'd1) begin
              state_d     = StDone;
              remaining_d = '0;
              done_d      = 1'b1;
            end else begin
              remaining_d = remaining_q - 8'd1;
            end
          end
        end
        StDone: begin
          if (phase_change) begin
            state_d = StLoad;
            phase_d = bus.phase_sel;
            mode_d  = mode_sel;
          end
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      phase_q     <= PhaseSoak;
      mode_q      <= Mode1;
      remaining_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      mode_q      <= mode_d;
      remaining_q <= remaining_d;
      done_q      <= done_d;
    end
  end

  assign bus.timer_done = done_q;
  assign bus.remaining  = remaining_q;
  assign bus.busy       = (state_q == StCount);
  assign bus.paused     = pause_active;

endmodule

// File: doc/wm_phase_timer.md
WM_PHASE_TIMER -- requirements
Module: wm_phase_timer

Interface
REQ-001 Parameter: UNIT_CYCLES, default 1000, clock cycles per time unit; legal range 2..65535.
REQ-002 clk  input  1  system clock, rising-edge active.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 timer_enable  input  1  run request from the wash controller.
REQ-005 phase_sel  input  2  00 soak, 01 wash, 10 rinse, 11 spin.
REQ-006 mode1, mode2, mode3  input  1 each  wash-mode selects; priority mode1 > mode2 > mode3; none set selects mode1.
REQ-007 lid  input  1  0 closed, 1 open.
REQ-008 timer_done  output  1  one-cycle pulse at phase expiry.
REQ-009 remaining  output  8  units left in the current phase.
REQ-010 busy  output  1  high while counting, including while paused.
REQ-011 paused  output  1  high while counting is frozen by an open lid.

Function
REQ-012 Durations SHALL be in units, indexed mode/phase as soak/wash/rinse/spin: mode1 2/4/3/2, mode2 4/8/6/4, mode3 8/16/12/8.
REQ-013 FSM states SHALL be IDLE, LOAD, COUNT, DONE.
REQ-014 IDLE -> LOAD when timer_enable=1.
REQ-015 LOAD SHALL last one cycle: latch phase_sel and mode, set remaining to the table duration D, clear the prescaler, then go to COUNT.
REQ-016 A table entry of 0 SHALL load as 1.
REQ-017 In COUNT, the prescaler SHALL increment each unpaused cycle and wrap at UNIT_CYCLES-1; remaining SHALL decrement on each wrap.
REQ-018 The wrap that takes remaining to 0 SHALL move the FSM to DONE and set timer_done high for exactly the first DONE cycle.
REQ-019 Latency: if timer_enable is first sampled at edge N, timer_done SHALL be high in the cycle after edge N+1+D*UNIT_CYCLES, with lid closed throughout.
REQ-020 DONE SHALL hold remaining=0 and busy=0 until timer_enable falls or phase_sel changes.
REQ-021 A phase_sel differing from the latched phase in COUNT or DONE, with timer_enable=1, SHALL go to LOAD.
REQ-022 timer_enable=0 in any state SHALL go to IDLE on the next edge, clearing remaining, the prescaler and timer_done.
REQ-023 Mode input changes after LOAD SHALL be ignored until the next LOAD.
REQ-024 Terminal wrap coinciding with timer_enable=0 SHALL go to IDLE with no timer_done pulse.
REQ-025 Terminal wrap coinciding with a phase_sel change SHALL go to LOAD with no timer_done pulse.
REQ-026 busy SHALL equal (state==COUNT); paused SHALL equal (state==COUNT && lid==1) when the pause feature is compiled in, else 0.

Reset
REQ-027 On rst_n=0: state IDLE, prescaler 0, latched phase 00, latched mode mode1, remaining 0, timer_done 0, busy 0, paused 0.
REQ-028 Reset asserted mid-phase SHALL abort the phase immediately with no timer_done pulse.
REQ-029 After rst_n deasserts, a still-high timer_enable SHALL start a fresh LOAD.

Configuration
REQ-030 Macro WM_LID_PAUSE_EN SHALL control lid handling.
REQ-031 With WM_LID_PAUSE_EN defined, lid=1 in COUNT SHALL freeze the prescaler and remaining; lid returning to 0 SHALL resume from the frozen values.
REQ-032 With WM_LID_PAUSE_EN undefined, lid SHALL be ignored and paused SHALL be tied to 0.

Structure
REQ-033 Shared package wm_pkg SHALL hold the phase encodings, the timer state enum, the mode index type and the 3x4 duration table constant.
REQ-034 Sub-module wm_prescaler SHALL implement the unit-tick counter with clear and hold inputs and a tick output.

Verification (UNIT_CYCLES=4)
REQ-035 mode2, phase 01, enable raised at edge 10 -> LOAD, timer_done single pulse after edge 43, remaining stepping 8..0 every 4 cycles.
REQ-036 mode1 soak expires, phase_sel steps to 01 two cycles later -> new LOAD with remaining=4, exactly one timer_done per phase.
REQ-037 WM_LID_PAUSE_EN defined, mode3 rinse, lid=1 for 10 cycles mid-count -> paused=1 for those cycles, timer_done delayed by exactly 10 cycles; macro undefined -> no delay, paused=0.
REQ-038 timer_enable dropped on the terminal-wrap cycle -> IDLE, remaining=0, no timer_done pulse.
REQ-039 rst_n pulsed low mid-wash with enable held high -> outputs zero at once, fresh LOAD after release, full duration recounted.
REQ-040 mode1 changed to mode3 mid-soak -> soak still expires after 2 units; the next phase uses mode3 durations.
